// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_param.
// The width parameters must match the FIFO instance they connect to.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  clr;
  logic                  push;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, push, w_data, pop,
    input  r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, push, w_data, pop,
    output r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FWFT FIFO with registered occupancy flags, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int AFULL_TH   = 3,
  parameter int AEMPTY_TH  = 1
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);
  localparam int                  DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  full_reg, empty_reg, af_reg, ae_reg;
  logic                  ovf_reg, udf_reg;
  logic                  wr_ok, rd_ok;

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign wr_ok = bus.push & (~full_reg | bus.pop);
  assign rd_ok = bus.pop & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    if (wr_ok & ~rd_ok)      count_next = count_reg + 1'b1;
    else if (rd_ok & ~wr_ok) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      af_reg    <= (AFULL_TH == 0);
      ae_reg    <= 1'b1;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else if (bus.clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      af_reg    <= (AFULL_TH == 0);
      ae_reg    <= 1'b1;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      count_reg <= count_next;
      // Flags come from the next count so they settle with the count register.
      full_reg  <= (count_next == DEPTH_C);
      empty_reg <= (count_next == '0);
      af_reg    <= (count_next >= AF_C);
      ae_reg    <= (count_next <= AE_C);
      ovf_reg   <= ovf_reg | (bus.push & ~wr_ok);
      udf_reg   <= udf_reg | (bus.pop & ~rd_ok);
    end
  end

  // Storage carries no reset; flush and reset only move the pointers.
  always_ff @(posedge clk) begin
    if (~rst & ~bus.clr & wr_ok) mem[wptr] <= bus.w_data;
  end

  assign bus.r_data       = empty_reg ? '0 : mem[rptr];
  assign bus.full         = full_reg;
  assign bus.empty        = empty_reg;
  assign bus.almost_full  = af_reg;
  assign bus.almost_empty = ae_reg;
  assign bus.count        = count_reg;
  assign bus.overflow     = ovf_reg;
  assign bus.underflow    = udf_reg;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param at default parameters (8b x 4).
module tb_sync_fifo_param;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] sb[$];
  logic          m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    int n;
    n = sb.size();
    chk({tag, ":count"}, 32'(bus.count), 32'(n));
    chk({tag, ":empty"}, 32'(bus.empty), 32'(n == 0));
    chk({tag, ":full"},  32'(bus.full),  32'(n == DEPTH));
    chk({tag, ":afull"}, 32'(bus.almost_full),  32'(n >= 3));
    chk({tag, ":aempty"}, 32'(bus.almost_empty), 32'(n <= 1));
    chk({tag, ":ovf"}, 32'(bus.overflow),  32'(m_ovf));
    chk({tag, ":udf"}, 32'(bus.underflow), 32'(m_udf));
    chk({tag, ":rdata"}, 32'(bus.r_data), (n == 0) ? 32'h0 : 32'(sb[0]));
  endtask

  task automatic model_clear();
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // One clock of stimulus: model the accept decision, score pops, then check state.
  task automatic step(input string tag, input logic ps, input logic [DW-1:0] d, input logic pp);
    logic wr, rd;
    logic [DW-1:0] e;
    bus.push = ps; bus.w_data = d; bus.pop = pp;
    wr = ps && (sb.size() < DEPTH || pp);
    rd = pp && (sb.size() > 0);
    if (rd) begin
      e = sb.pop_front();
      chk({tag, ":pop_data"}, 32'(bus.r_data), 32'(e));
    end
    if (wr) sb.push_back(d);
    if (ps && !wr) m_ovf = 1'b1;
    if (pp && !rd) m_udf = 1'b1;
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0;
    chk_state(tag);
  endtask

  task automatic do_clr(input string tag);
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    model_clear();
    chk_state(tag);
  endtask

  initial begin
    bus.clr = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.w_data = '0;
    model_clear();
    #12;
    chk_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill: flags walk through almost_empty -> almost_full -> full.
    step("fill0", 1, 8'h11, 0);
    step("fill1", 1, 8'h22, 0);
    step("fill2", 1, 8'h33, 0);
    step("fill3", 1, 8'h44, 0);
    step("ovf",   1, 8'h55, 0);
    for (int i = 0; i < 4; i++) step("drain", 0, 8'h00, 1);

    // Push+pop while full: no overflow, wrap preserves order.
    do_clr("clr1");
    step("refill0", 1, 8'h11, 0);
    step("refill1", 1, 8'h22, 0);
    step("refill2", 1, 8'h33, 0);
    step("refill3", 1, 8'h44, 0);
    step("full_pp", 1, 8'hAA, 1);
    for (int i = 0; i < 4; i++) step("wrap_pop", 0, 8'h00, 1);

    // Push+pop while empty: push taken, pop rejected.
    step("empty_pp", 1, 8'h5A, 1);
    step("empty_pp_pop", 0, 8'h00, 1);

    // Sustained streaming at occupancy 2.
    do_clr("clr2");
    step("s_pre0", 1, 8'hF0, 0);
    step("s_pre1", 1, 8'hF1, 0);
    for (int i = 0; i < 20; i++) step("stream", 1, 8'(i), 1);

    // Flush with count 3 and overflow set.
    do_clr("clr3");
    for (int i = 0; i < 4; i++) step("c_fill", 1, 8'(8'h60 + i), 0);
    step("c_ovf", 1, 8'h99, 0);
    step("c_pop", 0, 8'h00, 1);
    do_clr("clr4");

    // Asynchronous reset mid-push, observed before any clock edge.
    step("r_fill0", 1, 8'h21, 0);
    step("r_fill1", 1, 8'h22, 1);
    bus.push = 1'b1; bus.w_data = 8'h23;
    #2 rst = 1'b1;
    #1;
    model_clear();
    chk_state("async_rst");
    #1 rst = 1'b0;
    bus.push = 1'b0;
    step("post_rst", 1, 8'h77, 0);
    step("post_rst_pop", 0, 8'h00, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
